// File: rtl/fetch_prefetch_unit_if.sv
// Signal bundle between fetch_prefetch_unit, instruction memory and decode.
// master: the fetch unit; slave: memory/decode/branch side.
interface fetch_prefetch_unit_if #(
    parameter int WORD_LEN      = 32,
    parameter int MEM_CELL_SIZE = 8
);
    logic                     brTaken;
    logic [MEM_CELL_SIZE-1:0] brBasePC;
    logic [WORD_LEN-1:0]      brOffset;
    logic                     imemReq;
    logic [MEM_CELL_SIZE-1:0] imemAddr;
    logic                     imemReady;
    logic                     imemValid;
    logic [WORD_LEN-1:0]      imemData;
    logic                     getInstruction;
    logic                     instrValid;
    logic [WORD_LEN-1:0]      instruction;
    logic [MEM_CELL_SIZE-1:0] instrPC;

    modport master (
        input  brTaken, brBasePC, brOffset, imemReady, imemValid, imemData, getInstruction,
        output imemReq, imemAddr, instrValid, instruction, instrPC
    );

    modport slave (
        output brTaken, brBasePC, brOffset, imemReady, imemValid, imemData, getInstruction,
        input  imemReq, imemAddr, instrValid, instruction, instrPC
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// PC owner and prefetcher: one outstanding imem fetch, {PC, instr} FIFO, branch flush.
// Define FETCH_PERF_CNT_EN to add the fetchCount/flushCount performance counters.
module fetch_prefetch_unit #(
    parameter int WORD_LEN      = 32,
    parameter int MEM_CELL_SIZE = 8,
    parameter int BUF_DEPTH     = 4,
    parameter int PC_STEP       = 4,
    parameter int RESET_PC      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_prefetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           fetchCount,
    output logic [31:0]           flushCount
`endif
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // state   | meaning
    // IDLE    | may issue a fetch when the buffer has room
    // WAIT    | request accepted, response pending
    // DISCARD | response pending but made stale by a branch
    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} fetchStateT;

    fetchStateT               state, stateNext;
    logic [MEM_CELL_SIZE-1:0] pc, pcNext, reqPC, reqPCNext, brTarget;
    logic [WORD_LEN-1:0]      instrMem [BUF_DEPTH];
    logic [MEM_CELL_SIZE-1:0] pcMem [BUF_DEPTH];
    logic [PTR_W-1:0]         wrPtr, rdPtr;
    logic [CNT_W-1:0]         count, countNext;
    logic                     reqReg, handshake, push, pop, flush, notEmpty;

    assign brTarget  = bus.brBasePC + bus.brOffset[MEM_CELL_SIZE-1:0];
    assign flush     = bus.brTaken;
    assign handshake = reqReg && bus.imemReady;
    assign notEmpty  = (count != '0);
    assign pop       = bus.getInstruction && notEmpty && !flush;

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        reqPCNext = reqPC;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    reqPCNext = pc;
                    pcNext    = pc + MEM_CELL_SIZE'(PC_STEP);
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (bus.imemValid) begin
                    push      = !flush;
                    stateNext = IDLE;
                end else if (flush) begin
                    stateNext = DISCARD;
                end
            end
            DISCARD: begin
                if (bus.imemValid) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        // A redirect wins over the sequential PC; a request accepted now is already stale.
        if (flush) begin
            pcNext = brTarget;
            if (state == IDLE && handshake) stateNext = DISCARD;
        end
    end

    always_comb begin
        countNext = count;
        if (flush)              countNext = '0;
        else if (push && !pop)  countNext = count + CNT_W'(1);
        else if (pop && !push)  countNext = count - CNT_W'(1);
    end

    // imemReq is registered from the next-state values so it is glitch-free and low in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= MEM_CELL_SIZE'(RESET_PC);
            reqPC  <= '0;
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            reqReg <= 1'b0;
        end else begin
            state  <= stateNext;
            pc     <= pcNext;
            reqPC  <= reqPCNext;
            count  <= countNext;
            reqReg <= (stateNext == IDLE) && (countNext < CNT_W'(BUF_DEPTH));
            if (flush) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + PTR_W'(1);
                if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instrMem[wrPtr] <= bus.imemData;
            pcMem[wrPtr]    <= reqPC;
        end
    end

    assign bus.imemReq     = reqReg;
    assign bus.imemAddr    = pc;
    assign bus.instrValid  = notEmpty;
    assign bus.instruction = notEmpty ? instrMem[rdPtr] : '0;
    assign bus.instrPC     = notEmpty ? pcMem[rdPtr] : '0;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchCount <= '0;
            flushCount <= '0;
        end else begin
            if (push && fetchCount != '1)  fetchCount <= fetchCount + 32'd1;
            if (flush && flushCount != '1) flushCount <= flushCount + 32'd1;
        end
    end
`endif
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised successor of the single-shot fetch stage.
- Owns the program counter and issues word fetches to instruction memory through a req/ready request channel and a valid response channel.
- Buffers fetched {PC, instruction} pairs in a small prefetch FIFO, and supports branch redirect with flush of both the buffer and any in-flight response.
- Sits between instruction memory and decode; decode pops with getInstruction.

Parameters:
- WORD_LEN, 32, instruction width in bits.
- MEM_CELL_SIZE, 8, PC/address width in bits.
- BUF_DEPTH, 4, prefetch FIFO entries; must be a power of two and at least 2.
- PC_STEP, 4, PC increment per sequential fetch.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- brTaken  in  1  branch redirect this cycle.
- brBasePC  in  MEM_CELL_SIZE  PC of the branch instruction.
- brOffset  in  WORD_LEN  signed byte offset added to brBasePC.
- imemReq  out  1  fetch request valid.
- imemAddr  out  MEM_CELL_SIZE  fetch address.
- imemReady  in  1  memory accepts the request.
- imemValid  in  1  response data valid.
- imemData  in  WORD_LEN  response instruction word.
- getInstruction  in  1  decode pops the head entry.
- instrValid  out  1  buffer non-empty.
- instruction  out  WORD_LEN  head instruction.
- instrPC  out  MEM_CELL_SIZE  PC of the head instruction.

Behaviour:
- Reset (async, active-high): pc=RESET_PC, FIFO empty, state=IDLE, imemReq=0, instrValid=0, instruction=0, instrPC=0.
- Only one memory request is outstanding at a time.
- Branch target = brBasePC + brOffset[MEM_CELL_SIZE-1:0], modulo 2^MEM_CELL_SIZE. PC increment also wraps modulo 2^MEM_CELL_SIZE.
- imemReq = (state==IDLE) && (count<BUF_DEPTH). It is driven only from registers.
- imemAddr = pc. While imemReq=1 and imemReady=0, imemAddr holds stable.
- State IDLE:
  - Handshake (imemReq&&imemReady): reqPC<=pc, pc<=pc+PC_STEP, go to WAIT.
  - Handshake with brTaken in the same cycle: pc<=target, go to DISCARD.
- State WAIT:
  - imemValid: push {reqPC, imemData}, go to IDLE.
  - brTaken without imemValid: pc<=target, go to DISCARD.
  - brTaken with imemValid: data dropped, pc<=target, go to IDLE.
- State DISCARD:
  - imemValid: data dropped, go to IDLE.
  - brTaken: pc<=target, stay in DISCARD.
- Any brTaken: FIFO cleared, so instrValid=0 on the next cycle. A simultaneous getInstruction pop is ignored. brTaken has priority over every other event.
- FIFO outputs:
  - instrValid = count!=0; instruction and instrPC show the head combinationally.
  - Pop occurs when getInstruction && instrValid. getInstruction while empty is ignored.
  - Push and pop in the same cycle keep count unchanged. Overflow is impossible because issue requires count<BUF_DEPTH.
  - Read and write pointers wrap modulo BUF_DEPTH; count is $clog2(BUF_DEPTH)+1 bits.
- Latency (imemReady=1, response 1 cycle after accept): request in cycle N, push at the edge ending N+1, instrValid in N+2. Sustained rate is one instruction per 2 cycles.
- Reset asserted mid-request: state and FIFO clear immediately. A late imemValid arriving in IDLE is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output ports fetchCount (32) and flushCount (32), both reset to 0.
  - fetchCount increments on every FIFO push.
  - flushCount increments on every brTaken cycle.
  - Both counters saturate at 2^32-1.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Memory model: word = (addr>>2)+1, imemReady=1, 1-cycle response. Release reset, hold getInstruction=0 -> FIFO fills with 4 entries (PC 0,4,8,12 / instr 1,2,3,4), then imemReq stays 0.
- Pop all 4 entries with getInstruction=1 -> instruction sequence 1,2,3,4 with matching instrPC; fetching resumes at PC 16.
- brTaken=1, brBasePC=4, brOffset=16 while in WAIT -> in-flight response discarded, FIFO empty next cycle, next head is PC 20 / instr 6.
- brOffset=-8 (0xFFFFFFF8), brBasePC=4 -> target 0xFC (wrap); next fetches are 0xFC then 0x00.
- imemReady held 0 for 5 cycles -> imemReq=1 and imemAddr stable throughout; one fetch completes after imemReady rises.
- Assert rst during WAIT, then deliver a late imemValid -> FIFO stays empty and the first new request uses PC=RESET_PC.
